// File: rtl/rat_pkg.sv
// Shared RAT MCU types: program-counter address width and return-stack operation codes.
package rat_pkg;

  localparam int unsigned RAT_ADDR_W = 10;

  typedef logic [RAT_ADDR_W-1:0] rat_addr_t;

  typedef enum logic [1:0] {
    STK_NOP,
    STK_PUSH,
    STK_POP,
    STK_REPL
  } stk_op_e;

endpackage

// File: rtl/stack_regfile.sv
// Return-stack storage: DEPTH x ADDR_W registers, synchronous write, asynchronous read.
module stack_regfile #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       CLK,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [ADDR_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [ADDR_W-1:0]          rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // Contents are never reset; the owner tracks validity through its entry count.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_return_stack.sv
// Hardware return-address stack for CALL/RET: LIFO with full/empty status and sticky
// overflow/underflow flags. TOP is combinational so the PC can load it on the POP cycle.
module call_return_stack
  import rat_pkg::*;
#(
  parameter int unsigned ADDR_W = RAT_ADDR_W,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [ADDR_W-1:0] PUSH_DATA,
  input  logic              CLR_ERR,
  output logic [ADDR_W-1:0] TOP,
  output logic [CNT_W-1:0]  COUNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int unsigned IDX_W = CNT_W - 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [IDX_W-1:0]  idx, top_idx;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;
  logic              empty, full;
  stk_op_e           op;

  assign idx     = count_q[CNT_W-2:0];
  assign top_idx = idx - IDX_W'(1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));

  always_comb begin
    op = STK_NOP;
    unique case ({PUSH, POP})
      2'b00: op = STK_NOP;
      2'b10: op = STK_PUSH;
      2'b01: op = STK_POP;
      2'b11: op = STK_REPL;
      default: op = STK_NOP;
    endcase
  end

  // A new error in the same cycle as CLR_ERR wins over the clear.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q & ~CLR_ERR;
    unf_d   = unf_q & ~CLR_ERR;
    we      = 1'b0;
    waddr   = idx;
    unique case (op)
      STK_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      STK_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      STK_REPL: begin
        we = 1'b1;
        if (empty) begin
          unf_d   = 1'b1;
          waddr   = '0;
          count_d = CNT_W'(1);
        end else begin
          waddr = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_regfile #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .CLK  (CLK),
    .we   (we & ~RST),
    .waddr(waddr),
    .wdata(PUSH_DATA),
    .raddr(top_idx),
    .rdata(rdata)
  );

  assign TOP       = empty ? '0 : rdata;
  assign COUNT     = count_q;
  assign EMPTY     = empty;
  assign FULL      = full;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_call_return_stack.sv
// Self-checking bench for call_return_stack: directed table, hand-written corner cases,
// and randomized traffic checked against a queue-based LIFO model.
module tb_call_return_stack;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              PUSH = 1'b0;
  logic              POP = 1'b0;
  logic [ADDR_W-1:0] PUSH_DATA = '0;
  logic              CLR_ERR = 1'b0;
  logic [ADDR_W-1:0] TOP;
  logic [CNT_W-1:0]  COUNT;
  logic              EMPTY, FULL, OVERFLOW, UNDERFLOW;

  int vectors = 0;
  int miscompares = 0;

  call_return_stack #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PUSH     (PUSH),
    .POP      (POP),
    .PUSH_DATA(PUSH_DATA),
    .CLR_ERR  (CLR_ERR),
    .TOP      (TOP),
    .COUNT    (COUNT),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .OVERFLOW (OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst, push, pop, clr;
    logic [9:0]  data;
    logic [9:0]  exp_top;
    int          exp_count;
    logic        exp_ovf, exp_unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic rst, logic push, logic pop, logic clr,
                              logic [9:0] data, logic [9:0] top, int cnt, logic o, logic u);
    vec_t v;
    v.name = name; v.rst = rst; v.push = push; v.pop = pop; v.clr = clr; v.data = data;
    v.exp_top = top; v.exp_count = cnt; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  // Drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic rst, input logic push, input logic pop, input logic clr,
                      input logic [ADDR_W-1:0] data);
    @(negedge CLK);
    RST = rst; PUSH = push; POP = pop; CLR_ERR = clr; PUSH_DATA = data;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [ADDR_W-1:0] top, input int cnt,
                       input logic o, input logic u);
    logic exp_empty, exp_full;
    exp_empty = (cnt == 0);
    exp_full  = (cnt == DEPTH);
    vectors++;
    if (TOP !== top || COUNT !== CNT_W'(cnt) || EMPTY !== exp_empty || FULL !== exp_full ||
        OVERFLOW !== o || UNDERFLOW !== u) begin
      miscompares++;
      $display("FAIL %s: got top=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want top=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
               name, TOP, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW,
               top, cnt, exp_empty, exp_full, o, u);
    end
  endtask

  // Reference model state
  logic [ADDR_W-1:0] model_q[$];
  logic              m_ovf, m_unf;

  task automatic model_step(input logic rst, input logic push, input logic pop, input logic clr,
                            input logic [ADDR_W-1:0] data);
    if (rst) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (push && !pop) begin
      if (model_q.size() == DEPTH) m_ovf = 1'b1;
      else model_q.push_back(data);
    end else if (pop && !push) begin
      if (model_q.size() == 0) m_unf = 1'b1;
      else void'(model_q.pop_back());
    end else if (push && pop) begin
      if (model_q.size() == 0) begin
        m_unf = 1'b1;
        model_q.push_back(data);
      end else begin
        model_q[model_q.size()-1] = data;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] exp_top;
    logic              r, pu, po, cl;
    logic [ADDR_W-1:0] d;

    // Directed table
    tbl.push_back(mk("reset",        1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0));
    tbl.push_back(mk("idle",         0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0));
    tbl.push_back(mk("push101",      0, 1, 0, 0, 10'h101, 10'h101, 1, 0, 0));
    tbl.push_back(mk("push202",      0, 1, 0, 0, 10'h202, 10'h202, 2, 0, 0));
    tbl.push_back(mk("push303",      0, 1, 0, 0, 10'h303, 10'h303, 3, 0, 0));
    tbl.push_back(mk("pop1",         0, 0, 1, 0, 10'h000, 10'h202, 2, 0, 0));
    tbl.push_back(mk("pop2",         0, 0, 1, 0, 10'h000, 10'h101, 1, 0, 0));
    tbl.push_back(mk("pop3",         0, 0, 1, 0, 10'h000, 10'h000, 0, 0, 0));
    tbl.push_back(mk("pop_empty",    0, 0, 1, 0, 10'h000, 10'h000, 0, 0, 1));
    tbl.push_back(mk("hold_unf",     0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1));
    tbl.push_back(mk("clr_err",      0, 0, 0, 1, 10'h000, 10'h000, 0, 0, 0));
    tbl.push_back(mk("clr_pop_emp",  0, 0, 1, 1, 10'h000, 10'h000, 0, 0, 1));
    tbl.push_back(mk("clr_again",    0, 0, 0, 1, 10'h000, 10'h000, 0, 0, 0));
    tbl.push_back(mk("push055",      0, 1, 0, 0, 10'h055, 10'h055, 1, 0, 0));
    tbl.push_back(mk("push0aa",      0, 1, 0, 0, 10'h0AA, 10'h0AA, 2, 0, 0));
    tbl.push_back(mk("repl155",      0, 1, 1, 0, 10'h155, 10'h155, 2, 0, 0));
    tbl.push_back(mk("pop_after_rp", 0, 0, 1, 0, 10'h000, 10'h055, 1, 0, 0));
    tbl.push_back(mk("push0bb",      0, 1, 0, 0, 10'h0BB, 10'h0BB, 2, 0, 0));
    tbl.push_back(mk("push0cc",      0, 1, 0, 0, 10'h0CC, 10'h0CC, 3, 0, 0));
    tbl.push_back(mk("rst_w_push",   1, 1, 0, 0, 10'h3AB, 10'h000, 0, 0, 0));
    tbl.push_back(mk("push044",      0, 1, 0, 0, 10'h044, 10'h044, 1, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].data);
      check(tbl[i].name, tbl[i].exp_top, tbl[i].exp_count, tbl[i].exp_ovf, tbl[i].exp_unf);
    end

    // Fill to DEPTH, then overflow
    step(1, 0, 0, 0, '0);
    check("rst_fill", 10'h000, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 0, ADDR_W'(10'h010 + i));
      check("fill", ADDR_W'(10'h010 + i), i + 1, 0, 0);
    end
    step(0, 1, 0, 0, 10'h3FF);
    check("overflow", 10'h017, DEPTH, 1, 0);
    step(0, 0, 0, 1, '0);
    check("clr_ovf", 10'h017, DEPTH, 0, 0);
    step(0, 1, 0, 1, 10'h3FE);
    check("clr_vs_ovf", 10'h017, DEPTH, 1, 0);
    step(0, 0, 0, 1, '0);
    check("clr_ovf2", 10'h017, DEPTH, 0, 0);
    step(0, 1, 1, 0, 10'h155);
    check("repl_full", 10'h155, DEPTH, 0, 0);
    step(0, 0, 1, 0, '0);
    check("pop_full", 10'h016, DEPTH - 1, 0, 0);

    // Replace on empty still pushes
    step(1, 0, 0, 0, '0);
    check("rst_repl", 10'h000, 0, 0, 0);
    step(0, 1, 1, 0, 10'h033);
    check("repl_empty", 10'h033, 1, 0, 1);

    // Randomized traffic against the queue model
    step(1, 0, 0, 0, '0);
    model_step(1, 0, 0, 0, '0);
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 15) == 0);
      d  = ADDR_W'($urandom);
      step(r, pu, po, cl, d);
      model_step(r, pu, po, cl, d);
      exp_top = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
      check("random", exp_top, model_q.size(), m_ovf, m_unf);
    end

    @(negedge CLK);
    PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0; RST = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
